axi4_write_drop_responder: RTL and testbench
============================================

AXI4_WRITE_DROP_RESPONDER -- requirements
Module: axi4_write_drop_responder

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 4, meaning the width of the AW and B ID fields.
REQ-002 SHALL have parameter AXI_USER_WIDTH, default 4, meaning the width of the AW and B user fields.
REQ-003 SHALL have parameter ERR_RESP, 2 bits, default 2'b10 (SLVERR), meaning the BRESP value returned for every transaction.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports axi4_aclk and axi4_arst.
REQ-005 axi4_aclk  input  1  clock; all state changes on its rising edge.
REQ-006 axi4_arst  input  1  asynchronous active-high reset.
REQ-007 s_axi4_awid  input  AXI_ID_WIDTH  write address ID.
REQ-008 s_axi4_awlen  input  8  burst length minus 1.
REQ-009 s_axi4_awuser  input  AXI_USER_WIDTH  write address user field.
REQ-010 s_axi4_awvalid / s_axi4_awready  input / output  1 each  AW handshake.
REQ-011 s_axi4_wlast  input  1  last-beat marker. W data and strobe are not consumed.
REQ-012 s_axi4_wvalid / s_axi4_wready  input / output  1 each  W handshake.
REQ-013 s_axi4_bid  output  AXI_ID_WIDTH  response ID.
REQ-014 s_axi4_bresp  output  2  response code.
REQ-015 s_axi4_buser  output  AXI_USER_WIDTH  response user field.
REQ-016 s_axi4_bvalid / s_axi4_bready  output / input  1 each  B handshake.
REQ-017 wlast_err  output  1  one-cycle pulse on a burst-length/wlast mismatch.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement a three-state FSM with states IDLE, DRAIN, RESP; one write transaction is handled at a time.
REQ-020 IDLE: awready=1, wready=0, bvalid=0.
  - On an AW handshake (awvalid & awready): latch awid, awlen and awuser, clear the beat counter, and move to DRAIN next cycle.
REQ-021 DRAIN: awready=0, wready=1.
  - On each W handshake, increment the 8-bit beat counter.
  - The W handshake with counter == latched awlen is the final beat; move to RESP next cycle.
REQ-022 The final beat SHALL be decided by the counter only, never by wlast.
  - awlen=255 gives 256 beats with no counter overflow.
REQ-023 wlast_err SHALL pulse high for the cycle after any W handshake that is either of:
  - wlast=1 with counter != awlen;
  - wlast=0 with counter == awlen.
REQ-024 RESP: bvalid=1, bid=latched awid, buser=latched awuser, bresp=ERR_RESP; awready=0, wready=0.
  - On a B handshake, move to IDLE next cycle.
REQ-025 bid, bresp and buser SHALL be held stable while bvalid=1 and bready=0 (AXI stability rule).
REQ-026 awready and wready SHALL be decoded from the state register only, with no combinational path from any valid input.
REQ-027 Minimum latencies:
  - AW handshake in cycle n gives wready in n+1.
  - Final W handshake in cycle m gives bvalid in m+1.
  - B handshake in cycle k gives awready in k+1.
REQ-028 W beats offered in IDLE or RESP SHALL NOT be accepted (wready=0).
REQ-029 An AW offered outside IDLE SHALL be stalled (awready=0) until the FSM returns to IDLE.

Reset
REQ-030 When axi4_arst=1, the block SHALL immediately (asynchronously) enter IDLE.
  - Outputs: awready=1, wready=0, bvalid=0, wlast_err=0, busy=0, bid=0, buser=0, bresp=ERR_RESP.
  - Beat counter and latched fields cleared.
REQ-031 Reset asserted mid-burst or with bvalid pending SHALL abort the transaction with no B response issued.
  - Normal operation resumes on the first clock edge after reset deasserts.

Verification
REQ-032 awid=3, awlen=0, W beat with wlast=1 in the cycle after AW, bready=1 -> bvalid in the following cycle with bid=3, bresp=2'b10; awready=1 one cycle after the B handshake; wlast_err stays 0.
REQ-033 awlen=255, 256 back-to-back W beats, wlast only on beat 256 -> wready high for exactly 256 handshakes; then one B with the latched ID; no wlast_err.
REQ-034 awlen=3, wlast=1 on beat 2 -> wlast_err pulses once after beat 2, four beats still consumed; awlen=3 with wlast=0 on beat 4 -> wlast_err pulses after beat 4.
REQ-035 bready held 0 for 10 cycles in RESP, second AW presented -> bvalid, bid and buser stable throughout; awready=0 until one cycle after the B handshake; then the second AW is accepted.
REQ-036 axi4_arst pulsed after beat 2 of an awlen=7 burst -> outputs immediately at reset values, no B response ever issued; a fresh awlen=0 transaction then completes normally.

Source files
------------

// File: rtl/axi4_write_drop_responder_if.sv
// axi4_write_drop_responder_if
//   Purpose : AW/W/B channel bundle for the write-drop responder. Only the
//             signals the responder uses are carried: W data and strobe are
//             never consumed, so they are not part of the bundle.
//   Modports: slave  - the responder side (accepts AW/W, drives B)
//             master - the initiator side (drives AW/W, accepts B)
//   Signals : awid/awlen/awuser/awvalid/awready - write address channel
//             wlast/wvalid/wready                - write data channel (control only)
//             bid/bresp/buser/bvalid/bready      - write response channel
interface axi4_write_drop_responder_if #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
);
  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [7:0]                awlen;
  logic [AXI_USER_WIDTH-1:0] awuser;
  logic                      awvalid;
  logic                      awready;

  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic [AXI_USER_WIDTH-1:0] buser;
  logic                      bvalid;
  logic                      bready;

  modport slave (
    input  awid, awlen, awuser, awvalid,
    input  wlast, wvalid,
    input  bready,
    output awready, wready,
    output bid, bresp, buser, bvalid
  );

  modport master (
    output awid, awlen, awuser, awvalid,
    output wlast, wvalid,
    output bready,
    input  awready, wready,
    input  bid, bresp, buser, bvalid
  );
endinterface

// File: rtl/axi4_write_drop_responder.sv
// axi4_write_drop_responder
//   Purpose : AXI4 write sink that accepts one write transaction at a time,
//             discards all W beats and answers each burst with a single B
//             response carrying a fixed error code (ERR_RESP).
//   Ports   : axi4_aclk  - clock, all state changes on rising edge
//             axi4_arst  - asynchronous active-high reset
//             s_axi4     - AW/W/B channels (slave modport)
//             wlast_err  - one-cycle pulse after a W beat whose wlast does
//                          not agree with the beat count
//             busy       - high whenever the FSM is not IDLE
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | awready high, waiting for a write address
//   DRAIN | wready high, swallowing awlen+1 beats counted by beat_cnt_q
//   RESP  | bvalid high with latched ID/user, waiting for bready
module axi4_write_drop_responder #(
  parameter int         AXI_ID_WIDTH   = 4,
  parameter int         AXI_USER_WIDTH = 4,
  parameter logic [1:0] ERR_RESP       = 2'b10
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arst,
  axi4_write_drop_responder_if.slave  s_axi4,
  output logic                        wlast_err,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                    state_q;
  logic [AXI_ID_WIDTH-1:0]   awid_q;
  logic [7:0]                awlen_q;
  logic [AXI_USER_WIDTH-1:0] awuser_q;
  logic [7:0]                beat_cnt_q;

  logic                      awready_q;
  logic                      wready_q;
  logic                      bvalid_q;
  logic [AXI_ID_WIDTH-1:0]   bid_q;
  logic [AXI_USER_WIDTH-1:0] buser_q;
  logic                      wlast_err_q;
  logic                      busy_q;

  logic                      final_beat;

  // The final beat is decided by the counter alone; wlast is only checked.
  // Comparing before increment lets awlen=255 run 256 beats in 8 bits.
  assign final_beat = (beat_cnt_q == awlen_q);

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      state_q     <= IDLE;
      awid_q      <= '0;
      awlen_q     <= '0;
      awuser_q    <= '0;
      beat_cnt_q  <= '0;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      buser_q     <= '0;
      wlast_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wlast_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s_axi4.awvalid && awready_q) begin
            awid_q     <= s_axi4.awid;
            awlen_q    <= s_axi4.awlen;
            awuser_q   <= s_axi4.awuser;
            beat_cnt_q <= '0;
            state_q    <= DRAIN;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        DRAIN: begin
          if (s_axi4.wvalid && wready_q) begin
            beat_cnt_q  <= beat_cnt_q + 8'd1;
            // Mismatch when wlast disagrees with "this is the last beat".
            wlast_err_q <= s_axi4.wlast ^ final_beat;
            if (final_beat) begin
              state_q  <= RESP;
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= awid_q;
              buser_q  <= awuser_q;
            end
          end
        end
        RESP: begin
          // bid/buser only load on entry to RESP, so they stay put while stalled.
          if (s_axi4.bready && bvalid_q) begin
            state_q   <= IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi4.awready = awready_q;
  assign s_axi4.wready  = wready_q;
  assign s_axi4.bvalid  = bvalid_q;
  assign s_axi4.bid     = bid_q;
  assign s_axi4.buser   = buser_q;
  assign s_axi4.bresp   = ERR_RESP;
  assign wlast_err      = wlast_err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_axi4_write_drop_responder.sv
module tb_axi4_write_drop_responder;
  localparam int         IDW = 4;
  localparam int         UW  = 4;
  localparam logic [1:0] ERR = 2'b10;

  logic clk = 1'b0;
  logic rst;
  logic wlast_err;
  logic busy;

  always #5 clk = ~clk;

  axi4_write_drop_responder_if #(.AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW)) bus ();

  axi4_write_drop_responder #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_USER_WIDTH(UW),
    .ERR_RESP      (ERR)
  ) dut (
    .axi4_aclk(clk),
    .axi4_arst(rst),
    .s_axi4   (bus),
    .wlast_err(wlast_err),
    .busy     (busy)
  );

  int n_cmp;
  int n_mis;

  // Reference model state: per-beat wlast pattern, beats taken so far and
  // the wlast_err pulse the spec rule predicts for the last accepted beat.
  logic [255:0] wl;
  int           beat_i;
  logic         pend_err;

  logic [3:0]   r_id, r_user, r_id2, r_user2;
  logic [7:0]   r_len, r_len2;
  bit           r_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset();
    check("rst_awready", bus.awready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_wlast_err", wlast_err, 0);
    check("rst_busy", busy, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_buser", bus.buser, 0);
    check("rst_bresp", bus.bresp, ERR);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [3:0] user);
    int cyc;
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awlen   = len;
    bus.awuser  = user;
    bus.wvalid  = 1'b1;
    bus.wlast   = 1'b1;
    check("wready_idle", bus.wready, 0);
    cyc = 0;
    while (bus.awready !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("awready_idle", bus.awready, 1);
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wready_after_aw", bus.wready, 1);
    check("awready_after_aw", bus.awready, 0);
    check("busy_after_aw", busy, 1);
  endtask

  task automatic send_beats(input int len, input int n, input bit gaps);
    int hs, cyc;
    bit take;
    hs  = 0;
    cyc = 0;
    while (hs < n && cyc < 4 * n + 20) begin
      @(negedge clk);
      check("wlast_err_beat", wlast_err, pend_err);
      pend_err = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.wvalid = 1'b0;
      end else begin
        bus.wvalid = 1'b1;
        bus.wlast  = wl[beat_i];
      end
      take = bus.wvalid && bus.wready;
      @(posedge clk);
      if (take) begin
        pend_err = (wl[beat_i] != (beat_i == len));
        beat_i++;
        hs++;
      end
      cyc++;
    end
    check("beat_count", hs, n);
  endtask

  task automatic recv_b(input logic [3:0] id, input logic [3:0] user, input int delay,
                        input bit second, input logic [3:0] id2, input logic [7:0] len2,
                        input logic [3:0] user2);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("wlast_err_final", wlast_err, pend_err);
        pend_err = 1'b0;
      end
      bus.wvalid = (i == 0);
      bus.wlast  = 1'b0;
      if (second) begin
        bus.awvalid = 1'b1;
        bus.awid    = id2;
        bus.awlen   = len2;
        bus.awuser  = user2;
      end
      check("bvalid", bus.bvalid, 1);
      check("bid", bus.bid, id);
      check("buser", bus.buser, user);
      check("bresp", bus.bresp, ERR);
      check("awready_resp", bus.awready, 0);
      check("wready_resp", bus.wready, 0);
      check("busy_resp", busy, 1);
      bus.bready = (i == delay);
    end
    @(posedge clk);
    #1;
    bus.bready = 1'b0;
    bus.wvalid = 1'b0;
    check("bvalid_after_b", bus.bvalid, 0);
    check("awready_after_b", bus.awready, 1);
    check("busy_after_b", busy, 0);
    check("wlast_err_after_b", wlast_err, 0);
  endtask

  task automatic run_txn(input logic [3:0] id, input logic [7:0] len, input logic [3:0] user,
                         input bit gaps, input int delay);
    send_aw(id, len, user);
    beat_i   = 0;
    pend_err = 1'b0;
    send_beats(int'(len), int'(len) + 1, gaps);
    recv_b(id, user, delay, 1'b0, 4'h0, 8'h0, 4'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    wl          = '0;
    beat_i      = 0;
    pend_err    = 1'b0;
    bus.awvalid = 1'b0;
    bus.awid    = '0;
    bus.awlen   = '0;
    bus.awuser  = '0;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;
    rst         = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single-beat burst, wlast on the only beat
    wl = '0; wl[0] = 1'b1;
    run_txn(4'd3, 8'd0, 4'd5, 1'b0, 0);

    // 256-beat burst back to back, wlast only on the last
    wl = '0; wl[255] = 1'b1;
    run_txn(4'd9, 8'd255, 4'd12, 1'b0, 0);

    // early wlast on beat 2 of 4
    wl = '0; wl[1] = 1'b1; wl[3] = 1'b1;
    run_txn(4'd1, 8'd3, 4'd2, 1'b0, 1);

    // missing wlast on the final beat of 4
    wl = '0;
    run_txn(4'd2, 8'd3, 4'd7, 1'b0, 0);

    // B stalled 10 cycles with a second AW waiting
    r_id = 4'd11; r_user = 4'd6; r_len = 8'd1;
    r_id2 = 4'd13; r_user2 = 4'd14; r_len2 = 8'd2;
    wl = '0; wl[1] = 1'b1;
    send_aw(r_id, r_len, r_user);
    beat_i = 0; pend_err = 1'b0;
    send_beats(int'(r_len), int'(r_len) + 1, 1'b0);
    recv_b(r_id, r_user, 10, 1'b1, r_id2, r_len2, r_user2);
    wl = '0; wl[2] = 1'b1;
    send_aw(r_id2, r_len2, r_user2);
    beat_i = 0; pend_err = 1'b0;
    send_beats(int'(r_len2), int'(r_len2) + 1, 1'b0);
    recv_b(r_id2, r_user2, 0, 1'b0, 4'h0, 8'h0, 4'h0);

    // reset mid-burst: abort with no response, then a clean transaction
    wl = '0; wl[7] = 1'b1;
    send_aw(4'd6, 8'd7, 4'd2);
    beat_i = 0; pend_err = 1'b0;
    send_beats(7, 2, 1'b0);
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    rst = 1'b1;
    #1;
    check_reset();
    repeat (3) begin
      @(negedge clk);
      check("bvalid_in_reset", bus.bvalid, 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_b_after_abort", bus.bvalid, 0);
      check("awready_after_abort", bus.awready, 1);
    end
    bus.bready = 1'b0;
    pend_err = 1'b0;
    wl = '0; wl[0] = 1'b1;
    run_txn(4'hA, 8'd0, 4'h1, 1'b0, 0);

    // randomized transactions against the rule-based model
    for (int t = 0; t < 16; t++) begin
      r_id   = 4'($urandom_range(0, 15));
      r_user = 4'($urandom_range(0, 15));
      r_len  = 8'($urandom_range(0, 12));
      r_bad  = ($urandom_range(0, 3) == 0);
      wl = '0;
      for (int i = 0; i <= int'(r_len); i++) begin
        if (r_bad) wl[i] = 1'($urandom_range(0, 1));
        else       wl[i] = (i == int'(r_len));
      end
      run_txn(r_id, r_len, r_user, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
